pipeline_skid_reg: RTL and testbench

- Two-entry pipeline stage for the valid/ready stage-to-stage handshake.
- Registers the backward ready path as well as the forward valid/data path.
- ready_o is driven only by internal state, so there is no combinational path from ready_i to ready_o.
- Inserted between core pipeline stages where the ready chain limits timing. Gives full throughput (one transfer per cycle), preserves FIFO order, and accepts flush on branch mispredict.

---
 rtl/pipeline_skid_reg_if.sv | 32 +++
 rtl/pipeline_skid_reg.sv | 108 ++++++++++
 tb/tb_pipeline_skid_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_skid_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_skid_reg_if
//  Description : valid/ready handshake bundle for one pipeline_skid_reg stage,
//                upstream and downstream sides, plus flush and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_skid_reg_if #(
  parameter type T_DATA = logic [31:0]
);
  logic       flush_i;
  logic       valid_i;
  logic       ready_o;
  T_DATA      data_i;
  logic       valid_o;
  logic       ready_i;
  T_DATA      data_o;
  logic [1:0] occupancy_o;

  // Stage side: consumes upstream/downstream controls, produces outputs
  modport slave (
    input  flush_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, occupancy_o
  );

  // Environment side: drives the stage and observes its outputs
  modport master (
    output flush_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, occupancy_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_skid_reg
//  Description : Two-entry skid-buffer pipeline stage. Both valid_o and
//                ready_o come straight from flops, cutting the combinational
//                ready chain while keeping one transfer per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_skid_reg #(
  parameter type T_DATA = logic [31:0]
) (
  input  wire                       clk_i,
  input  wire                       rst_i,
  pipeline_skid_reg_if.slave        bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t     r_state;
  T_DATA      r_main;
  T_DATA      r_skid;
  logic       r_valid;
  logic       r_ready;
  logic [1:0] r_occ;

  // Handshake inputs as seen by the state machine this cycle
  logic w_in;
  logic w_out;
  assign w_in  = bus.valid_i;
  assign w_out = bus.ready_i;

  // State, storage and registered handshake outputs; reset > flush > normal
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_occ   <= 2'd0;
    end else if (bus.flush_i) begin
      // Entries are dropped by clearing valid only; payload regs keep contents
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_occ   <= 2'd0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          // Downstream ready is irrelevant with nothing to offer
          if (w_in) begin
            r_main  <= bus.data_i;
            r_state <= S_BUSY;
            r_valid <= 1'b1;
            r_ready <= 1'b1;
            r_occ   <= 2'd1;
          end
        end
        S_BUSY: begin
          if (w_in && w_out) begin
            // Streaming: replace the consumed head with the new beat
            r_main <= bus.data_i;
          end else if (w_in) begin
            // Head is stalled, park the new beat behind it
            r_skid  <= bus.data_i;
            r_state <= S_FULL;
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_occ   <= 2'd2;
          end else if (w_out) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_occ   <= 2'd0;
          end
        end
        S_FULL: begin
          // ready_o is low here, so upstream valid is not sampled; the drain
          // cycle moves skid to head and reopens ready on the next cycle
          if (w_out) begin
            r_main  <= r_skid;
            r_state <= S_BUSY;
            r_valid <= 1'b1;
            r_ready <= 1'b1;
            r_occ   <= 2'd1;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_occ   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.data_o      = r_main;
  assign bus.valid_o     = r_valid;
  assign bus.ready_o     = r_ready;
  assign bus.occupancy_o = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_skid_reg
//  Description : Self-checking bench for pipeline_skid_reg. A queue model of
//                held entries predicts ready/valid/occupancy and supplies the
//                expected payload for every downstream transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_skid_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] q[$];

  pipeline_skid_reg_if #(.T_DATA(logic [31:0])) bus ();

  pipeline_skid_reg #(.T_DATA(logic [31:0])) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare pre-edge outputs with the model, apply the edge to the model,
  // then advance to 1 time unit after the rising edge.
  task automatic step();
    logic        up;
    logic        dn;
    logic [31:0] exp;
    int          occ;
    occ = q.size();
    chk("ready_o", {31'd0, bus.ready_o}, {31'd0, occ != 2});
    chk("valid_o", {31'd0, bus.valid_o}, {31'd0, occ != 0});
    chk("occupancy_o", {30'd0, bus.occupancy_o}, occ);
    chk("occ_not_3", {31'd0, bus.occupancy_o == 2'd3}, 32'd0);
    if (rst || bus.flush_i) begin
      q.delete();
    end else begin
      dn = (occ != 0) && bus.ready_i;
      up = bus.valid_i && (occ != 2);
      if (dn) begin
        exp = q.pop_front();
        chk("data_o", bus.data_o, exp);
      end
      if (up) q.push_back(bus.data_i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.ready_o}, 32'd1);
    chk({tag, "_data"}, bus.data_o, 32'd0);
    chk({tag, "_occ"}, {30'd0, bus.occupancy_o}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset for two cycles with valid_i high
    rst         = 1'b1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hDEAD_BEEF;
    bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Streaming 1..8 with downstream always ready
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = i;
      step();
      chk("stream_head", bus.data_o, i);
    end
    bus.valid_i = 1'b0;
    step();
    step();

    // Backpressure: fill both entries, then hold 0x33 while full
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h11;
    step();
    bus.data_i  = 32'h22;
    step();
    chk("bp_full_head", bus.data_o, 32'h11);
    bus.data_i = 32'h33;
    repeat (3) step();
    bus.ready_i = 1'b1;
    step();
    chk("bp_drain_head", bus.data_o, 32'h22);
    step();
    bus.valid_i = 1'b0;
    step();
    step();

    // Flush while full, with downstream ready in the same cycle
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h11;
    step();
    bus.data_i  = 32'h22;
    step();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    bus.ready_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    repeat (3) step();

    // Flush with an upstream beat in EMPTY: 0xAA dropped, 0xBB kept
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hAA;
    bus.ready_i = 1'b0;
    step();
    bus.flush_i = 1'b0;
    bus.data_i  = 32'hBB;
    step();
    chk("flush_next_data", bus.data_o, 32'hBB);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    step();
    step();

    // Reset mid-operation from FULL
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h55;
    step();
    bus.data_i  = 32'h66;
    step();
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    step();
    rst = 1'b0;
    chk_reset_vals("midreset");
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h77;
    step();
    chk("post_reset_data", bus.data_o, 32'h77);
    bus.valid_i = 1'b0;
    repeat (3) step();

    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
